// File: rtl/iterative_alu_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative 1-bit-per-cycle shifter,
// valid/ready on both sides with a registered result, zero and illegal-op flags.
module iterative_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       alu_control_op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o,
    output logic             busy_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);
    localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             long_shift_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] comb_result_s;
    logic [WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0] acc_r;
    logic [SHW-1:0]   cnt_r;
    logic [1:0]       shift_op_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             illegal_r;

    assign shamt_s  = operand_b_i[SHW-1:0];
    assign accept_s = in_valid_i && (state_r == ST_IDLE);

    // Only legal shifts with a nonzero amount take the iterative path; shamt 0 finishes in one cycle.
    assign long_shift_s = (alu_control_op_i[3] == 1'b0) && (alu_control_op_i[2] == 1'b1)
                        && (alu_control_op_i[1:0] != 2'b10) && (shamt_s != CNT_ZERO);

    // Single-cycle result; shifts here only ever see shamt 0, so they pass operand A through.
    always_comb begin
        comb_result_s = {WIDTH{1'b0}};
        case (alu_control_op_i)
            4'b0000: comb_result_s = operand_a_i & operand_b_i;
            4'b0001: comb_result_s = operand_a_i | operand_b_i;
            4'b0010: comb_result_s = operand_a_i + operand_b_i;
            4'b0011: comb_result_s = operand_a_i ^ operand_b_i;
            4'b0100: comb_result_s = operand_a_i;
            4'b0101: comb_result_s = operand_a_i;
            4'b0110: comb_result_s = operand_a_i - operand_b_i;
            4'b0111: comb_result_s = operand_a_i;
            default: comb_result_s = {WIDTH{1'b0}};
        endcase
    end

    // One-bit shift step of the accumulator for the latched shift kind.
    always_comb begin
        acc_step_s = acc_r;
        case (shift_op_r)
            2'b00:   acc_step_s = {acc_r[WIDTH-2:0], 1'b0};
            2'b01:   acc_step_s = {1'b0, acc_r[WIDTH-1:1]};
            2'b11:   acc_step_s = {acc_r[WIDTH-1], acc_r[WIDTH-1:1]};
            default: acc_step_s = acc_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (long_shift_s) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: operand capture at accept, shift iteration, result/flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= CNT_ZERO;
            shift_op_r <= 2'b00;
            result_r   <= {WIDTH{1'b0}};
            zero_r     <= 1'b1;
            illegal_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        illegal_r <= alu_control_op_i[3];
                        if (long_shift_s) begin
                            acc_r      <= operand_a_i;
                            cnt_r      <= shamt_s;
                            shift_op_r <= alu_control_op_i[1:0];
                        end else begin
                            result_r <= comb_result_s;
                            zero_r   <= (comb_result_s == {WIDTH{1'b0}});
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        result_r <= acc_step_s;
                        zero_r   <= (acc_step_s == {WIDTH{1'b0}});
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_r == ST_IDLE);
    assign out_valid_o = (state_r == ST_DONE);
    assign busy_o      = (state_r != ST_IDLE);
    assign result_o    = result_r;
    assign zero_o      = zero_r;
    assign illegal_o   = illegal_r;

endmodule

// File: tb/tb_iterative_alu_unit.sv
// Bench for iterative_alu_unit: directed vector table, hand-written multi-cycle sequences,
// and random operations checked against an arithmetic reference model.
module tb_iterative_alu_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  alu_control_op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    iterative_alu_unit #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .alu_control_op_i(alu_control_op_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .zero_o(zero_o), .illegal_o(illegal_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: result defined directly from the operation's arithmetic meaning.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0: return {1'b0, a & b};
            4'd1: return {1'b0, a | b};
            4'd2: return {1'b0, 32'(a + b)};
            4'd3: return {1'b0, a ^ b};
            4'd4: return {1'b0, a << sh};
            4'd5: return {1'b0, a >> sh};
            4'd6: return {1'b0, 32'(a - b)};
            4'd7: return {1'b0, 32'($signed(a) >>> sh)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && (b % 32) != 0)
            return int'(b % 32) + 1;
        return 1;
    endfunction

    // Issue one op from IDLE (called at a negedge), wait for the result, complete the handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eres, input logic ezero,
                          input logic eill, input int elat);
        int lat;
        check({tag, "_in_ready"}, {31'd0, in_ready_o}, 32'd1);
        alu_control_op_i = op;
        operand_a_i = a;
        operand_b_i = b;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!out_valid_o && lat < 40);
        check({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_result"}, result_o, eres);
        check({tag, "_zero"}, {31'd0, zero_o}, {31'd0, ezero});
        check({tag, "_illegal"}, {31'd0, illegal_o}, {31'd0, eill});
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        int seen;
        int busy_cnt;
        logic [32:0] r;

        vecs[0]  = '{"add",      4'b0010, 32'd7,          32'd5,          32'd12,         1'b0, 1'b0, 1};
        vecs[1]  = '{"sub_wrap", 4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 1};
        vecs[2]  = '{"sub_zero", 4'b0110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1};
        vecs[3]  = '{"srl4",     4'b0101, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0, 5};
        vecs[4]  = '{"sll0",     4'b0100, 32'd1,          32'd0,          32'd1,          1'b0, 1'b0, 1};
        vecs[5]  = '{"sll31",    4'b0100, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 32};
        vecs[6]  = '{"illegal",  4'b1010, 32'hFFFF_FFFF,  32'd3,          32'd0,          1'b1, 1'b1, 1};
        vecs[7]  = '{"and",      4'b0000, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1'b0, 1};
        vecs[8]  = '{"or",       4'b0001, 32'hA000_0001,  32'h0500_0010,  32'hA500_0011,  1'b0, 1'b0, 1};
        vecs[9]  = '{"xor",      4'b0011, 32'h1234_5678,  32'h1234_5678,  32'd0,          1'b1, 1'b0, 1};
        vecs[10] = '{"add_ovf",  4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1};
        vecs[11] = '{"sll_hi_b", 4'b0100, 32'd1,          32'h0000_0021,  32'd2,          1'b0, 1'b0, 2};
        vecs[12] = '{"sra_pos",  4'b0111, 32'h4000_0000,  32'd30,         32'd1,          1'b0, 1'b0, 31};
        vecs[13] = '{"srl_zero", 4'b0101, 32'd1,          32'd1,          32'd0,          1'b1, 1'b0, 2};

        rst_i = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        alu_control_op_i = 4'd0;
        operand_a_i = 32'd0;
        operand_b_i = 32'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_result", result_o, 32'd0);
        check("rst_zero", {31'd0, zero_o}, 32'd1);
        check("rst_illegal", {31'd0, illegal_o}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].zero, vecs[i].ill, vecs[i].lat);

        // sra with busy counting; in_valid held during the op must be ignored.
        alu_control_op_i = 4'b0111;
        operand_a_i = 32'h8000_0000;
        operand_b_i = 32'd4;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        alu_control_op_i = 4'b0010;
        operand_a_i = 32'd1;
        operand_b_i = 32'd1;
        busy_cnt = 0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (busy_o) busy_cnt++;
            if (in_ready_o && c < 5) seen++;
            if (out_valid_o) begin
                in_valid_i = 1'b0;
                check("sra_result", result_o, 32'hF800_0000);
            end
        end
        in_valid_i = 1'b0;
        check("sra_busy_cycles", busy_cnt, 32'd5);
        check("sra_busy_not_ready", seen, 32'd0);
        check("sra_back_idle", {31'd0, busy_o}, 32'd0);

        // Backpressure: result held through 10 stalled cycles.
        out_ready_i = 1'b0;
        alu_control_op_i = 4'b0010;
        operand_a_i = 32'd3;
        operand_b_i = 32'd4;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            operand_a_i = $urandom;
            check("bp_valid", {31'd0, out_valid_o}, 32'd1);
            check("bp_result", result_o, 32'd7);
            check("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
        end
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("bp_release_valid", {31'd0, out_valid_o}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready_o}, 32'd1);

        // Reset in the middle of a long shift aborts it.
        alu_control_op_i = 4'b0100;
        operand_a_i = 32'd1;
        operand_b_i = 32'd20;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("mid_busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_result", result_o, 32'd0);
        check("mid_rst_zero", {31'd0, zero_o}, 32'd1);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i);
            if (out_valid_o) seen++;
        end
        check("mid_rst_no_valid", seen, 32'd0);
        run_op("post_rst_illegal", 4'b1010, 32'd5, 32'd6, 32'd0, 1'b1, 1'b1, 1);

        // Random ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(4, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            r = ref_alu(op, a, b);
            run_op("rand", op, a, b, r[31:0], (r[31:0] == 32'd0), r[32], ref_lat(op, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
